// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus sweeper: walks every input vector of a combinational DUT,
// captures its single output per vector and compares against an expected table.
module truth_table_sweeper #(
  parameter int                   N_IN   = 4,
  parameter int                   HOLD   = 20,
  parameter logic [(2**N_IN)-1:0] EXPECT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        vec,
  input  logic                   dut_f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   fail_valid
);

  localparam int T  = 2**N_IN;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [T-1:0]    table_q, table_d;
  logic [N_IN:0]   mcnt_q, mcnt_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  // NOTE: every next-state signal is defaulted to its held value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    ff_d    = ff_q;
    fv_d    = fv_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          mcnt_d  = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == CW'(HOLD - 1)) begin
          // End of hold window: DUT output has settled, capture and score it.
          table_d[vec_q] = dut_f;
          if (dut_f != EXPECT[vec_q]) begin
            mcnt_d = mcnt_q + (N_IN + 1)'(1);
            if (!fv_q) begin
              ff_d = vec_q;
              fv_d = 1'b1;
            end
          end
          cnt_d = '0;
          if (vec_q == N_IN'(T - 1)) state_d = DONE;
          else                       vec_d   = vec_q + N_IN'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec          = vec_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign pass         = (state_q == DONE) && (mcnt_q == '0);
  assign table_out    = table_q;
  assign mismatch_cnt = mcnt_q;
  assign first_fail   = ff_q;
  assign fail_valid   = fv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (matching/faulty DUT, stuck-at-0,
// 2-input XOR at HOLD=1) with a done-triggered scoreboard monitor.
module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  mcnt;
    logic [3:0]  ff;
    logic        fv;
    logic        pass;
  } res_t;

  localparam logic [15:0] EXP_A = 16'hA5C3;
  localparam logic [15:0] EXP_B = 16'hFFFF;
  localparam logic [3:0]  EXP_C = 4'b0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  res_t q_a[$];
  res_t q_b[$];
  res_t q_c[$];

  // Instance A: 4 inputs, HOLD=20, DUT model can inject a fault on vector 9
  logic        start_a = 1'b0, fault_en = 1'b0;
  logic [3:0]  vec_a, ff_a;
  logic        dut_f_a, busy_a, done_a, pass_a, fv_a;
  logic [15:0] tbl_a;
  logic [4:0]  mc_a;
  assign dut_f_a = EXP_A[vec_a] ^ (fault_en && (vec_a == 4'd9));

  truth_table_sweeper #(.N_IN(4), .HOLD(20), .EXPECT(EXP_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .dut_f(dut_f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .table_out(tbl_a),
    .mismatch_cnt(mc_a), .first_fail(ff_a), .fail_valid(fv_a));

  // Instance B: stuck-at-0 DUT against an all-ones table
  logic        start_b = 1'b0;
  logic [3:0]  vec_b, ff_b;
  logic        busy_b, done_b, pass_b, fv_b;
  logic [15:0] tbl_b;
  logic [4:0]  mc_b;

  truth_table_sweeper #(.N_IN(4), .HOLD(20), .EXPECT(EXP_B)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .dut_f(1'b0),
    .busy(busy_b), .done(done_b), .pass(pass_b), .table_out(tbl_b),
    .mismatch_cnt(mc_b), .first_fail(ff_b), .fail_valid(fv_b));

  // Instance C: 2-input XOR, one cycle per vector
  logic        start_c = 1'b0;
  logic [1:0]  vec_c, ff_c;
  logic        dut_f_c, busy_c, done_c, pass_c, fv_c;
  logic [3:0]  tbl_c;
  logic [2:0]  mc_c;
  assign dut_f_c = vec_c[1] ^ vec_c[0];

  truth_table_sweeper #(.N_IN(2), .HOLD(1), .EXPECT(EXP_C)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .vec(vec_c), .dut_f(dut_f_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .table_out(tbl_c),
    .mismatch_cnt(mc_c), .first_fail(ff_c), .fail_valid(fv_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [15:0] t, input logic [4:0] m,
                              input logic [3:0] f, input logic v, input logic p);
    res_t r;
    r.tbl = t; r.mcnt = m; r.ff = f; r.fv = v; r.pass = p;
    return r;
  endfunction

  task automatic score(input string tag, input res_t exp, input res_t act);
    check({tag, "_table"},      32'(act.tbl),  32'(exp.tbl));
    check({tag, "_mismatch"},   32'(act.mcnt), 32'(exp.mcnt));
    check({tag, "_first_fail"}, 32'(act.ff),   32'(exp.ff));
    check({tag, "_fail_valid"}, 32'(act.fv),   32'(exp.fv));
    check({tag, "_pass"},       32'(act.pass), 32'(exp.pass));
  endtask

  // Monitor: on every rising done, pop the expected result and compare.
  initial begin
    logic pa, pb, pc;
    res_t e;
    pa = 1'b0; pb = 1'b0; pc = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a && !pa) begin
        if (q_a.size() == 0) check("a_unexpected_done", 32'(q_a.size()), 32'd1);
        else begin e = q_a.pop_front(); score("a", e, mk(tbl_a, mc_a, ff_a, fv_a, pass_a)); end
      end
      if (done_b && !pb) begin
        if (q_b.size() == 0) check("b_unexpected_done", 32'(q_b.size()), 32'd1);
        else begin e = q_b.pop_front(); score("b", e, mk(tbl_b, mc_b, ff_b, fv_b, pass_b)); end
      end
      if (done_c && !pc) begin
        if (q_c.size() == 0) check("c_unexpected_done", 32'(q_c.size()), 32'd1);
        else begin
          e = q_c.pop_front();
          score("c", e, mk({12'b0, tbl_c}, {2'b0, mc_c}, {2'b0, ff_c}, fv_c, pass_c));
        end
      end
      pa = done_a; pb = done_b; pc = done_c;
    end
  end

  task automatic check_reset_a(input string tag);
    check({tag, "_vec"},  32'(vec_a), 0);
    check({tag, "_flags"}, 32'({busy_a, done_a, pass_a, fv_a}), 0);
    check({tag, "_table"}, 32'(tbl_a), 0);
    check({tag, "_mcnt_ff"}, 32'({mc_a, ff_a}), 0);
  endtask

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  // Counts RUN cycles until busy drops; called at the first negedge after the start edge.
  task automatic wait_sweep_a(input string tag);
    int n = 0;
    while (busy_a && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd320);
    check({tag, "_done"}, 32'(done_a), 32'd1);
  endtask

  initial begin
    int n;
    // Reset: outputs at reset values, start ignored while rst is high
    @(negedge clk);
    check_reset_a("rst_a");
    check("rst_b_table", 32'({tbl_b, mc_b, busy_b, done_b}), 0);
    check("rst_c", 32'({vec_c, busy_c, done_c, pass_c, tbl_c, mc_c}), 0);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("rst_start_ignored", 32'({busy_a, done_a}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Matching DUT
    q_a.push_back(mk(16'hA5C3, 5'd0, 4'd0, 1'b0, 1'b1));
    pulse_a();
    wait_sweep_a("match");
    check("match_vec_hold", 32'(vec_a), 32'd15);

    // Single fault on vector 9, restarted straight from DONE
    fault_en = 1'b1;
    q_a.push_back(mk(16'hA7C3, 5'd1, 4'd9, 1'b1, 1'b0));
    pulse_a();
    wait_sweep_a("fault");

    // Restart from DONE with fixed DUT: results clear on the start edge
    fault_en = 1'b0;
    q_a.push_back(mk(16'hA5C3, 5'd0, 4'd0, 1'b0, 1'b1));
    pulse_a();
    check("restart_clear", 32'({mc_a, fv_a, pass_a}), 0);
    check("restart_vec", 32'(vec_a), 0);
    wait_sweep_a("restart");

    // Reset mid-sweep at vector 7: no result expected from the aborted sweep
    pulse_a();
    n = 0;
    while (vec_a != 4'd7 && n < 1000) begin n++; @(negedge clk); end
    check("midrst_reach_vec7", 32'(vec_a), 32'd7);
    rst = 1'b1;
    #1;
    check_reset_a("midrst");
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'({done_a, busy_a}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean sweep after reset, with an ignored start pulse during RUN
    q_a.push_back(mk(16'hA5C3, 5'd0, 4'd0, 1'b0, 1'b1));
    pulse_a();
    n = 1;
    while (vec_a != 4'd3 && n < 1000) begin n++; @(negedge clk); end
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("run_start_ignored_vec", 32'(vec_a), 32'd3);
    check("run_start_ignored_busy", 32'(busy_a), 32'd1);
    n = 0;
    while (!done_a && n < 1000) begin n++; @(negedge clk); end
    check("post_reset_done", 32'(done_a), 32'd1);

    // Stuck-at-0 against all-ones: count reaches T without wrapping
    q_b.push_back(mk(16'h0000, 5'b10000, 4'd0, 1'b1, 1'b0));
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (!done_b && n < 1000) begin n++; @(negedge clk); end
    check("stuck_done", 32'(done_b), 32'd1);

    // N_IN=2, HOLD=1: vec steps every cycle, done 4 cycles after the start edge
    q_c.push_back(mk(16'h0006, 5'd0, 4'd0, 1'b0, 1'b1));
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("xor_vec%0d", k), 32'({busy_c, vec_c}), 32'({1'b1, 2'(k)}));
      @(negedge clk);
    end
    check("xor_done_at_4", 32'({done_c, busy_c, vec_c}), 32'({1'b1, 1'b0, 2'd3}));

    repeat (2) @(negedge clk);
    check("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
